// File: rtl/cache_ctrl_nway_if.sv
// CPU request/response and main-memory req/ack signals of the N-way cache controller.
// slave is the controller's view; master is the CPU + memory side driving it.
interface cache_ctrl_nway_if #(
    parameter int ADDR_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [3:0]        cpu_be;
    logic              cpu_ready;
    logic              cpu_ack;
    logic [31:0]       cpu_rdata;
    logic              cpu_hit;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, mem_ack, mem_rdata,
        output cpu_ready, cpu_ack, cpu_rdata, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, mem_ack, mem_rdata,
        input  cpu_ready, cpu_ack, cpu_rdata, cpu_hit, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_ctrl_nway.sv
// N-way set-associative write-back/write-allocate cache, one word per line, round-robin victims.
// Hit: ack 2 edges after accept; a miss adds one or two memory transactions; cpu_ready low while busy.
module cache_ctrl_nway #(
    parameter int ADDR_W = 32,
    parameter int WAYS   = 2,
    parameter int SETS   = 256,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    cache_ctrl_nway_if.slave bus,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);
    localparam int INDEX_W = $clog2(SETS);
    localparam int TAG_W   = ADDR_W - INDEX_W - 2;
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND} state_t;
    state_t state_q, state_d;

    logic               req_we_q;
    logic [TAG_W-1:0]   req_tag_q;
    logic [INDEX_W-1:0] req_idx_q;
    logic [31:0]        req_wdata_q;
    logic [3:0]         req_be_q;
    logic [WAY_W-1:0]   vic_q;
    logic [31:0]        rdata_q;
    logic               hit_q;

    logic [WAYS-1:0]    valid_q  [SETS];
    logic [WAYS-1:0]    dirty_q  [SETS];
    logic [WAY_W-1:0]   vptr_q   [SETS];
    logic [TAG_W-1:0]   tag_mem  [WAYS][SETS];
    logic [31:0]        data_mem [WAYS][SETS];

    logic               hit, any_inv;
    logic [WAY_W-1:0]   hit_way, inv_way, vic_way, vptr_nxt;
    logic [31:0]        hit_data, hit_merged, fill_data;
    logic               addr_lsb_unused;

    assign addr_lsb_unused = ^bus.cpu_addr[1:0];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) res[8*b +: 8] = be[b] ? wd[8*b +: 8] : old[8*b +: 8];
        return res;
    endfunction

    // Descending scan so the lowest-numbered matching / invalid way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        any_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[req_idx_q][w] && tag_mem[w][req_idx_q] == req_tag_q) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[req_idx_q][w]) begin
                any_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        vic_way    = any_inv ? inv_way : vptr_q[req_idx_q];
        vptr_nxt   = (WAYS > 1) ? vptr_q[req_idx_q] + 1'b1 : '0;
        hit_data   = data_mem[hit_way][req_idx_q];
        hit_merged = merge(hit_data, req_wdata_q, req_be_q);
        fill_data  = req_we_q ? merge(bus.mem_rdata, req_wdata_q, req_be_q) : bus.mem_rdata;
    end

    always_comb begin
        state_d       = state_q;
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state_q)
            IDLE:    if (bus.cpu_req) state_d = LOOKUP;
            LOOKUP: begin
                if (hit)
                    state_d = RESPOND;
                else if (valid_q[req_idx_q][vic_way] && dirty_q[req_idx_q][vic_way])
                    state_d = WRITEBACK;
                else
                    state_d = REFILL;
            end
            WRITEBACK: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {tag_mem[vic_q][req_idx_q], req_idx_q, 2'b00};
                bus.mem_wdata = data_mem[vic_q][req_idx_q];
                if (bus.mem_ack) state_d = REFILL;
            end
            REFILL: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = {req_tag_q, req_idx_q, 2'b00};
                if (bus.mem_ack) state_d = RESPOND;
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.cpu_ready = (state_q == IDLE);
    assign bus.cpu_ack   = (state_q == RESPOND);
    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_hit   = hit_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            req_we_q    <= 1'b0;
            req_tag_q   <= '0;
            req_idx_q   <= '0;
            req_wdata_q <= '0;
            req_be_q    <= '0;
            vic_q       <= '0;
            rdata_q     <= '0;
            hit_q       <= 1'b0;
            hit_cnt     <= '0;
            miss_cnt    <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                vptr_q[s]  <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (bus.cpu_req) begin
                    req_we_q    <= bus.cpu_we;
                    req_tag_q   <= bus.cpu_addr[ADDR_W-1:INDEX_W+2];
                    req_idx_q   <= bus.cpu_addr[INDEX_W+1:2];
                    req_wdata_q <= bus.cpu_wdata;
                    req_be_q    <= bus.cpu_be;
                end
                LOOKUP: if (hit) begin
                    hit_q   <= 1'b1;
                    rdata_q <= req_we_q ? hit_merged : hit_data;
                    if (req_we_q) dirty_q[req_idx_q][hit_way] <= 1'b1;
                    if (hit_cnt != {CNT_W{1'b1}}) hit_cnt <= hit_cnt + 1'b1;
                end else begin
                    hit_q <= 1'b0;
                    vic_q <= vic_way;
                    if (!any_inv) vptr_q[req_idx_q] <= vptr_nxt;
                    if (miss_cnt != {CNT_W{1'b1}}) miss_cnt <= miss_cnt + 1'b1;
                end
                REFILL: if (bus.mem_ack) begin
                    valid_q[req_idx_q][vic_q] <= 1'b1;
                    dirty_q[req_idx_q][vic_q] <= req_we_q;
                    rdata_q                   <= fill_data;
                end
                default: ;
            endcase
        end
    end

    // Tag/data arrays carry no reset; only valid bits qualify their contents.
    always_ff @(posedge clk) begin
        if (state_q == LOOKUP && hit && req_we_q)
            data_mem[hit_way][req_idx_q] <= hit_merged;
        if (state_q == REFILL && bus.mem_ack) begin
            data_mem[vic_q][req_idx_q] <= fill_data;
            tag_mem[vic_q][req_idx_q]  <= req_tag_q;
        end
    end
endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Scoreboard bench for cache_ctrl_nway: directed accesses push expected CPU responses and
// memory transactions; independent monitors pop and compare as the DUT presents them.
module tb_cache_ctrl_nway;
    localparam int ADDR_W = 32;
    localparam int WAYS   = 2;
    localparam int SETS   = 256;
    localparam int CNT_W  = 4;
    localparam int CMAX   = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [CNT_W-1:0] hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    cache_ctrl_nway_if #(.ADDR_W(ADDR_W)) bus ();

    cache_ctrl_nway #(.ADDR_W(ADDR_W), .WAYS(WAYS), .SETS(SETS), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
    );

    typedef struct { logic [31:0] rdata; logic hit; } cpu_exp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; } mem_exp_t;

    cpu_exp_t    cpu_q[$];
    mem_exp_t    mem_q[$];
    logic [31:0] mem_model [logic [31:0]];
    int          mem_lat   = 3;
    int          n_tests   = 0;
    int          n_fail    = 0;
    int          sb_hits   = 0;
    int          sb_misses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        mem_q.push_back('{we, addr, wdata});
    endtask

    // CPU-side monitor
    initial begin : cpu_mon
        cpu_exp_t e;
        forever begin
            @(negedge clk);
            if (rst && bus.cpu_ack === 1'b1) begin
                if (cpu_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_cpu_ack: got ack with rdata 0x%08h, expected none", bus.cpu_rdata);
                end else begin
                    e = cpu_q.pop_front();
                    check("cpu_rdata", bus.cpu_rdata, e.rdata);
                    check("cpu_hit", 32'(bus.cpu_hit), 32'(e.hit));
                end
            end
        end
    end

    // Memory model and memory-side monitor
    initial begin : mem_resp
        logic [31:0] a, d;
        logic        w;
        bit          aborted, skip;
        mem_exp_t    e;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        skip = 0;
        forever begin
            if (!skip) @(negedge clk);
            skip = 0;
            if (rst && bus.mem_req === 1'b1) begin
                a = bus.mem_addr;
                w = bus.mem_we;
                d = bus.mem_wdata;
                aborted = 0;
                for (int i = 1; i < mem_lat && !aborted; i++) begin
                    @(negedge clk);
                    if (!rst || bus.mem_req !== 1'b1) aborted = 1;
                    else begin
                        check("mem_addr_stable", bus.mem_addr, a);
                        check("mem_we_stable", 32'(bus.mem_we), 32'(w));
                    end
                end
                if (!aborted) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = w ? 32'h0 : (mem_model.exists(a) ? mem_model[a] : (a ^ 32'h5A5A_0000));
                    if (w) mem_model[a] = d;
                    if (mem_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_mem_txn: got we=%0d addr 0x%08h, expected none", w, a);
                    end else begin
                        e = mem_q.pop_front();
                        check("mem_we", 32'(w), 32'(e.we));
                        check("mem_addr", a, e.addr);
                        if (e.we) check("mem_wdata", d, e.wdata);
                    end
                    @(negedge clk);
                    bus.mem_ack = 1'b0;
                    skip = 1;
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
        int t = 0;
        while (bus.cpu_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got cpu_ready=0 for 100 cycles, expected 1");
        end
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        bus.cpu_be    = be;
        @(negedge clk);
        bus.cpu_req = 1'b0;
    endtask

    task automatic wait_ack(output int lat);
        lat = 1;
        while (bus.cpu_ack !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL ack_timeout: got no cpu_ack in 200 cycles, expected one");
        end
    endtask

    task automatic check_counters();
        check("hit_cnt", 32'(hit_cnt), 32'(sb_hits));
        check("miss_cnt", 32'(miss_cnt), 32'(sb_misses));
        check("mem_txns_done", 32'(mem_q.size()), 32'd0);
    endtask

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] exp_rdata, input logic exp_hit);
        int lat;
        cpu_q.push_back('{exp_rdata, exp_hit});
        if (exp_hit) sb_hits   = (sb_hits   == CMAX) ? CMAX : sb_hits + 1;
        else         sb_misses = (sb_misses == CMAX) ? CMAX : sb_misses + 1;
        issue(we, addr, wdata, be);
        wait_ack(lat);
        if (exp_hit) check("hit_latency", 32'(lat), 32'd2);
        check_counters();
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lat;
        int t;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.cpu_be    = '0;
        mem_model[32'h0000_0040] = 32'hDEAD_BEEF;
        mem_model[32'h0000_0440] = 32'h1111_1111;
        mem_model[32'h0000_0840] = 32'h2222_2222;

        #2;
        check("rst_cpu_ready", 32'(bus.cpu_ready), 32'd1);
        check("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_cpu_rdata", bus.cpu_rdata, 32'd0);
        check_counters();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Cold miss then hit, write hit with byte enables
        push_mem(1'b0, 32'h40, 32'h0);
        access(1'b0, 32'h40, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0);
        access(1'b0, 32'h40, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b1);
        access(1'b1, 32'h40, 32'h0000_1234, 4'b0011, 32'hDEAD_1234, 1'b1);
        access(1'b0, 32'h40, 32'h0, 4'hF, 32'hDEAD_1234, 1'b1);

        // Fill way 1, then dirty eviction of way 0
        push_mem(1'b0, 32'h440, 32'h0);
        access(1'b0, 32'h440, 32'h0, 4'hF, 32'h1111_1111, 1'b0);
        push_mem(1'b1, 32'h40, 32'hDEAD_1234);
        push_mem(1'b0, 32'h840, 32'h0);
        access(1'b0, 32'h840, 32'h0, 4'hF, 32'h2222_2222, 1'b0);

        // Pointer now 1: way 1 (clean 0x440) is evicted, 0x840 stays resident
        push_mem(1'b0, 32'h40, 32'h0);
        access(1'b0, 32'h40, 32'h0, 4'hF, 32'hDEAD_1234, 1'b0);
        access(1'b0, 32'h840, 32'h0, 4'hF, 32'h2222_2222, 1'b1);

        // Write miss merges into refilled word; later evicted dirty
        push_mem(1'b0, 32'hC40, 32'h0);
        access(1'b1, 32'hC40, 32'hAABB_CCDD, 4'b1100, 32'hAABB_0C40, 1'b0);
        access(1'b0, 32'h40, 32'h0, 4'hF, 32'hDEAD_1234, 1'b1);
        push_mem(1'b0, 32'h840, 32'h0);
        access(1'b0, 32'h840, 32'h0, 4'hF, 32'h2222_2222, 1'b0);
        access(1'b0, 32'hC40, 32'h0, 4'hF, 32'hAABB_0C40, 1'b1);
        push_mem(1'b1, 32'hC40, 32'hAABB_0C40);
        push_mem(1'b0, 32'h1040, 32'h0);
        access(1'b0, 32'h1040, 32'h0, 4'hF, 32'h5A5A_1040, 1'b0);

        // Memory stall with ignored cpu_req pulses
        push_mem(1'b0, 32'h1000, 32'h0);
        cpu_q.push_back('{32'h5A5A_1000, 1'b0});
        sb_misses++;
        mem_lat = 10;
        issue(1'b0, 32'h1000, 32'h0, 4'hF);
        for (int i = 0; i < 8; i++) begin
            check("stall_cpu_ready", 32'(bus.cpu_ready), 32'd0);
            if (i > 0) begin
                check("stall_mem_req", 32'(bus.mem_req), 32'd1);
                check("stall_mem_addr", bus.mem_addr, 32'h1000);
                check("stall_mem_we", 32'(bus.mem_we), 32'd0);
            end
            bus.cpu_req  = i[0];
            bus.cpu_we   = 1'b1;
            bus.cpu_addr = 32'h2000;
            @(negedge clk);
        end
        bus.cpu_req = 1'b0;
        wait_ack(lat);
        check_counters();
        mem_lat = 3;

        // Reset in the middle of a refill
        push_mem(1'b0, 32'h3000, 32'h0);
        cpu_q.push_back('{32'h5A5A_3000, 1'b0});
        mem_lat = 10;
        issue(1'b0, 32'h3000, 32'h0, 4'hF);
        t = 0;
        while (bus.mem_req !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("mid_mem_req_seen", 32'(bus.mem_req), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        cpu_q.delete();
        mem_q.delete();
        sb_hits   = 0;
        sb_misses = 0;
        check("arst_mem_req", 32'(bus.mem_req), 32'd0);
        check("arst_cpu_ready", 32'(bus.cpu_ready), 32'd1);
        check_counters();
        repeat (2) @(negedge clk);
        rst     = 1'b1;
        mem_lat = 3;
        @(negedge clk);

        // Valid bits cleared: 0x40 misses and refills the written-back word
        push_mem(1'b0, 32'h40, 32'h0);
        access(1'b0, 32'h40, 32'h0, 4'hF, 32'hDEAD_1234, 1'b0);

        // Saturation of the 4-bit hit counter
        for (int i = 0; i < 20; i++)
            access(1'b0, 32'h40, 32'h0, 4'hF, 32'hDEAD_1234, 1'b1);
        check("hit_cnt_saturated", 32'(hit_cnt), 32'd15);

        repeat (3) @(negedge clk);
        check("cpu_resp_drained", 32'(cpu_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
